// File: rtl/pic_dot_sequencer.sv
// pic_dot_sequencer
//
// Sequences one product-in-FIFO multiplier (PIC) through a sparse dot product.
// Two index-sorted sparse streams (A = row, B = column) are merged by index;
// every index present in both streams produces one PIC write carrying the two
// 16-bit values. Products are then drained from the PIC FIFO with read pulses
// and summed into a wrapping ACC_W-bit accumulator.
//
// Handshake: an element on a stream is consumed in exactly the cycles where
// <x>_valid and <x>_ready are both high at the rising clock edge. <x>_ready is
// combinational from the current state, the valid inputs and the indices, and
// is never asserted while the matching <x>_valid is low.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start                   one-cycle pulse, honoured only when idle
//   a_* / b_*               sparse input streams (valid/ready/idx/val/last)
//   pic_A0, pic_B0          PIC operands, meaningful while pic_write is high
//   pic_write, pic_read     PIC push / pop strobes (never high together)
//   pic_fifo_out            PIC FIFO head, valid the cycle after pic_read
//   busy                    high from accepted start until done
//   done                    one-cycle pulse, result valid
//   result                  sum of matched products, held until next done
//   match_count             matches found in the current/last dot product
//   dbg_state               current FSM state (IDLE=0 .. DONE=4)

module pic_dot_sequencer #(
  parameter int IDX_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ACC_W      = 40
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [IDX_W-1:0] a_idx,
  input  logic [15:0]      a_val,
  input  logic             a_last,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [IDX_W-1:0] b_idx,
  input  logic [15:0]      b_val,
  input  logic             b_last,
  output logic [15:0]      pic_A0,
  output logic [15:0]      pic_B0,
  output logic             pic_write,
  output logic             pic_read,
  input  logic [31:0]      pic_fifo_out,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result,
  output logic [IDX_W:0]   match_count,
  output logic [2:0]       dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MERGE = 3'd1,
    S_DRAIN = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [PW-1:0]    pending;   // products written but not yet popped
  logic             exh_a;
  logic             exh_b;
  logic             rd_d;      // a pop was issued last cycle: head data valid now
  logic [ACC_W-1:0] acc;

  logic             match;
  logic             exh_a_nxt;
  logic             exh_b_nxt;
  logic [ACC_W-1:0] acc_nxt;

  assign dbg_state = state;

  // Merge decision. Nothing is consumed while the PIC FIFO is full, so the
  // number of undrained products can never exceed FIFO_DEPTH.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    match   = 1'b0;
    if (state == S_MERGE && pending != DEPTH_P) begin
      if (!exh_a && !exh_b) begin
        if (a_valid && b_valid) begin
          if (a_idx == b_idx) begin
            a_ready = 1'b1;
            b_ready = 1'b1;
            match   = 1'b1;
          end else if (a_idx < b_idx) begin
            a_ready = 1'b1;
          end else begin
            b_ready = 1'b1;
          end
        end
      end else if (exh_a && !exh_b) begin
        // A is finished: remaining B elements can never match, discard them.
        b_ready = b_valid;
      end else if (!exh_a && exh_b) begin
        a_ready = a_valid;
      end
    end
  end

  assign exh_a_nxt = exh_a | (a_ready & a_last);
  assign exh_b_nxt = exh_b | (b_ready & b_last);

  // Head data is summed one cycle after its pop, whatever state we are in,
  // so a pop issued just before leaving DRAIN is never lost.
  assign acc_nxt = acc + (rd_d ? {{(ACC_W-32){1'b0}}, pic_fifo_out} : {ACC_W{1'b0}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pending     <= '0;
      exh_a       <= 1'b0;
      exh_b       <= 1'b0;
      rd_d        <= 1'b0;
      acc         <= '0;
      pic_A0      <= '0;
      pic_B0      <= '0;
      pic_write   <= 1'b0;
      pic_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      match_count <= '0;
    end else begin
      pic_write <= match;
      if (match) begin
        pic_A0 <= a_val;
        pic_B0 <= b_val;
      end
      pic_read <= 1'b0;
      done     <= 1'b0;
      rd_d     <= pic_read;
      acc      <= acc_nxt;
      exh_a    <= exh_a_nxt;
      exh_b    <= exh_b_nxt;

      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_MERGE;
            acc         <= '0;
            match_count <= '0;
            pending     <= '0;
            exh_a       <= 1'b0;
            exh_b       <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_MERGE: begin
          if (match) begin
            pending     <= pending + 1'b1;
            match_count <= match_count + 1'b1;
          end
          if (pending == DEPTH_P || (exh_a_nxt && exh_b_nxt)) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // pic_read is only ever set from here, and pic_write only from a
          // MERGE match, so the two strobes can never overlap.
          if (pending != '0) begin
            pic_read <= 1'b1;
            pending  <= pending - 1'b1;
          end else if (exh_a && exh_b) begin
            state <= S_FINAL;
          end else begin
            state <= S_MERGE;
          end
        end
        S_FINAL: begin
          // acc_nxt already includes the final pop's data.
          result <= acc_nxt;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
